// File: rtl/abcd_pkg.sv
// Shared types for the A/B/C/D sweep generator.
// Optional macro ABCD_GRAY_EN selects a reflected-Gray drive mapping.
package abcd_pkg;

  localparam int NUM_COMBOS = 16;

  typedef logic [3:0] idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

  // Gray mapping keeps single-input transitions, including the 15 -> 0 wrap.
  function automatic idx_t map_abcd(input idx_t v);
`ifdef ABCD_GRAY_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

endpackage

// File: rtl/abcd_sweep_gen_step_debounce.sv
// Step button conditioning: two-flop synchroniser, stable-level counter and
// a registered one-cycle pulse on each accepted rising edge.
module step_debounce #(
  parameter int DB_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_pulse
);

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  logic [1:0] r_sync;
  logic       r_level;
  logic       r_level_d;
  logic [7:0] r_cnt;
  logic       r_pulse;
  logic       w_differs;

  assign w_differs = r_sync[1] ^ r_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= 2'b00;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= 8'd0;
      r_pulse   <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_raw};
      r_level_d <= r_level;
      r_pulse   <= r_level & ~r_level_d;
      // Any cycle agreeing with the current level restarts the stability count.
      if (w_differs) begin
        if (r_cnt == DB_LAST) begin
          r_level <= r_sync[1];
          r_cnt   <= 8'd0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end else begin
        r_cnt <= 8'd0;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/abcd_sweep_gen.sv
// Drives the A/B/C/D inputs of the decode stage: timed auto sweep or manual
// stepping. Define ABCD_GRAY_EN for a Gray-coded drive; idx stays binary.
module abcd_sweep_gen
  import abcd_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int DB_CYCLES   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       step,
  input  logic       mode,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic [3:0] idx,
  output logic       valid,
  output logic       done
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam idx_t       IDX_LAST  = idx_t'(NUM_COMBOS - 1);

  sweep_state_t r_state;
  sweep_state_t w_state_next;
  idx_t         r_idx;
  idx_t         w_idx_next;
  logic [7:0]   r_hold;
  logic [7:0]   w_hold_next;
  logic         r_valid;
  logic         w_new_idx;
  logic         w_step_pulse;
  idx_t         w_abcd;

  step_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_step_debounce (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (step),
    .o_pulse(w_step_pulse)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_hold  <= 8'd0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_hold  <= w_hold_next;
      r_valid <= ~w_new_idx;
    end
  end

  // A start also counts as a new presentation, even if idx was already 0.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_hold_next  = r_hold;
    w_new_idx    = 1'b0;
    case (r_state)
      IDLE: begin
        if (mode) begin
          if (start) begin
            w_state_next = RUN;
            w_idx_next   = '0;
            w_hold_next  = 8'd0;
            w_new_idx    = 1'b1;
          end
        end else if (w_step_pulse) begin
          w_idx_next = r_idx + 4'd1;
          w_new_idx  = 1'b1;
        end
      end
      RUN: begin
        if (r_hold == HOLD_LAST) begin
          if (r_idx == IDX_LAST) begin
            w_state_next = DONE;
          end else begin
            w_idx_next  = r_idx + 4'd1;
            w_hold_next = 8'd0;
            w_new_idx   = 1'b1;
          end
        end else begin
          w_hold_next = r_hold + 8'd1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_abcd       = map_abcd(r_idx);
  assign {A, B, C, D} = w_abcd;
  assign idx          = r_idx;
  assign valid        = r_valid;
  assign done         = (r_state == DONE);

endmodule

// File: tb/tb_abcd_sweep_gen.sv
// Scoreboard bench for abcd_sweep_gen: expected per-cycle outputs are queued
// when stimulus is applied and compared on the falling edge of that cycle.
module tb_abcd_sweep_gen;

  localparam int HOLD = 4;
  localparam int DB   = 3;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       step  = 1'b0;
  logic       mode  = 1'b0;
  logic       A, B, C, D;
  logic [3:0] idx;
  logic       valid;
  logic       done;

  always #5 clk = ~clk;

  abcd_sweep_gen #(
    .HOLD_CYCLES(HOLD),
    .DB_CYCLES  (DB)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .step (step),
    .mode (mode),
    .A    (A),
    .B    (B),
    .C    (C),
    .D    (D),
    .idx  (idx),
    .valid(valid),
    .done (done)
  );

  typedef struct {
    int         cyc;
    logic [3:0] idx;
    logic       valid;
    logic       done;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] exp_abcd(input logic [3:0] v);
`ifdef ABCD_GRAY_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] i, input logic v, input logic d, input string tag);
    exp_t e;
    e.cyc = c; e.idx = i; e.valid = v; e.done = d; e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Sweep expectations for n cycles; cycle c=1 is the one right after the start edge.
  task automatic push_sweep(input int t, input int n, input string tag);
    for (int c = 1; c <= n; c++) begin
      if (c <= 16 * HOLD)
        push(t + c - 1, 4'((c - 1) / HOLD), ((c - 1) % HOLD) != 0, 1'b0, tag);
      else
        push(t + c - 1, 4'd15, 1'b1, c == 16 * HOLD + 1, tag);
    end
  endtask

  task automatic wait_until(input int target);
    for (int k = 0; k < 2000 && cyc < target; k++) @(negedge clk);
    if (cyc < target) check_eq("wait_timeout", 32'(cyc), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_idx"},   32'(idx),          32'd0);
    check_eq({tag, "_abcd"},  32'({A, B, C, D}), 32'd0);
    check_eq({tag, "_valid"}, 32'(valid),        32'd0);
    check_eq({tag, "_done"},  32'(done),         32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    check_eq("rst_held_valid", 32'(valid), 32'd0);
    rst = 1'b0;
    push(cyc + 1, 4'd0, 1'b1, 1'b0, "rst_release");
    @(negedge clk);
  endtask

  task automatic auto_start(output int t);
    @(negedge clk);
    mode  = 1'b1;
    start = 1'b1;
    t     = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Clean press held well past the debounce window: exactly one increment.
  task automatic press(input logic [3:0] old_v, input string tag);
    int e;
    logic [3:0] nv;
    nv = old_v + 4'd1;
    @(negedge clk);
    mode = 1'b0;
    step = 1'b1;
    e    = cyc + 1;
    push(e + DB + 2, old_v, 1'b1, 1'b0, tag);
    push(e + DB + 3, nv, 1'b0, 1'b0, tag);
    for (int k = DB + 4; k <= 30; k++) push(e + k, nv, 1'b1, 1'b0, tag);
    repeat (12) @(negedge clk);
    step = 1'b0;
    wait_until(e + 31);
  endtask

  task automatic glitch(input logic [3:0] cur);
    int g;
    @(negedge clk);
    mode = 1'b0;
    step = 1'b1;
    g    = cyc + 1;
    for (int k = 0; k < 15; k++) push(g + k, cur, 1'b1, 1'b0, "glitch");
    repeat (DB - 1) @(negedge clk);
    step = 1'b0;
    wait_until(g + 15);
  endtask

  logic [3:0] prev_idx  = 4'd0;
  logic [3:0] prev_abcd = 4'd0;

  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      check_eq({e.tag, "_cyc"},   32'(cyc),          32'(e.cyc));
      check_eq({e.tag, "_idx"},   32'(idx),          32'(e.idx));
      check_eq({e.tag, "_abcd"},  32'({A, B, C, D}), 32'(exp_abcd(e.idx)));
      check_eq({e.tag, "_valid"}, 32'(valid),        32'(e.valid));
      check_eq({e.tag, "_done"},  32'(done),         32'(e.done));
      $display("[TB] cyc %0d %s idx=%0d abcd=%b valid=%b done=%b", cyc, e.tag, idx, {A, B, C, D}, valid, done);
    end
`ifdef ABCD_GRAY_EN
    if (!rst && idx != prev_idx)
      check_eq("gray_one_toggle", 32'($countones({A, B, C, D} ^ prev_abcd)), 32'd1);
`endif
    prev_idx  = idx;
    prev_abcd = {A, B, C, D};
  end

  initial begin
    int t;
    int base;

    // Power-on reset, observed mid-cycle.
    #12;
    check_reset_outputs("por");
    release_reset();

    // Start with mode=0 is ignored.
    @(negedge clk);
    mode  = 1'b0;
    start = 1'b1;
    base  = cyc + 1;
    for (int k = 0; k < 6; k++) push(base + k, 4'd0, 1'b1, 1'b0, "start_manual");
    @(negedge clk);
    start = 1'b0;
    wait_until(base + 6);

    // Plain auto sweep.
    auto_start(t);
    push_sweep(t, 16 * HOLD + 2, "sweep");
    wait_until(t + 16 * HOLD + 2);

    // Manual wrap 15 -> 0, glitch rejection, then a normal increment.
    press(4'd15, "wrap");
    glitch(4'd0);
    press(4'd0, "manual");

    // Sweep with start, step and mode disturbances during RUN.
    auto_start(t);
    push_sweep(t, 16 * HOLD + 2, "disturbed");
    wait_until(t + 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t + 12);
    mode = 1'b0;
    wait_until(t + 14);
    step = 1'b1;
    wait_until(t + 24);
    step = 1'b0;
    wait_until(t + 30);
    mode = 1'b1;
    wait_until(t + 40);
    mode = 1'b0;
    wait_until(t + 16 * HOLD + 2);

    // Reset mid-sweep while idx=7, then a fresh sweep from 0.
    auto_start(t);
    push_sweep(t, 7 * HOLD + 2, "pre_reset");
    wait_until(t + 7 * HOLD + 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    release_reset();
    auto_start(t);
    push_sweep(t, 16 * HOLD + 2, "post_reset");
    wait_until(t + 16 * HOLD + 2);

    repeat (3) @(negedge clk);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
